// File: rtl/ab_lag_checker.sv
// Checks that every a is followed by b exactly LAG enabled cycles later and
// every b was preceded by a LAG enabled cycles earlier; reports pulses, counts and first-fail info.
module ab_lag_checker #(
  parameter int LAG   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_p,
  output logic             fwd_fail_p,
  output logic             bwd_fail_p,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    ARMED  = 2'd2
  } state_t;

  localparam logic [3:0]       WARM_LAST = 4'(LAG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_next;
  logic [LAG-1:0]   r_hist;
  logic [LAG-1:0]   w_hist_nxt;
  logic [3:0]       r_wcnt;
  logic             w_check;
  logic             w_x;
  logic             w_pass;
  logic             w_fwd;
  logic             w_bwd;
  logic             w_fail;

  assign w_check = (r_state == ARMED) && en && !clr;
  assign w_x     = r_hist[LAG-1];
  assign w_pass  = w_check &&  w_x &&  b;
  assign w_fwd   = w_check &&  w_x && !b;
  assign w_bwd   = w_check && !w_x &&  b;
  assign w_fail  = w_fwd || w_bwd;
  assign state   = r_state;

  // Loop form keeps the shift legal for LAG=1, where there is no lower slice.
  always_comb begin
    w_hist_nxt    = '0;
    w_hist_nxt[0] = a;
    for (int i = 1; i < LAG; i++) begin
      w_hist_nxt[i] = r_hist[i-1];
    end
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = en ? WARMUP : IDLE;
    end else if (!en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = WARMUP;
        WARMUP:  if (r_wcnt == WARM_LAST) w_next = ARMED;
        ARMED:   w_next = ARMED;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist         <= '0;
      r_wcnt         <= '0;
      pass_p         <= 1'b0;
      fwd_fail_p     <= 1'b0;
      bwd_fail_p     <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err_sticky     <= 1'b0;
      first_fail_cyc <= '0;
      cyc_cnt        <= '0;
    end else if (!en) begin
      r_hist     <= '0;
      r_wcnt     <= '0;
      pass_p     <= 1'b0;
      fwd_fail_p <= 1'b0;
      bwd_fail_p <= 1'b0;
    end else begin
      pass_p     <= w_pass;
      fwd_fail_p <= w_fwd;
      bwd_fail_p <= w_bwd;
      if (r_state != IDLE) r_hist <= w_hist_nxt;
      if (r_state == WARMUP && r_wcnt != WARM_LAST) begin
        r_wcnt <= r_wcnt + 4'd1;
      end else begin
        r_wcnt <= '0;
      end
      if (cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + 1'b1;
      if (w_pass && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (w_fail && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      // Only the first fail since rst/clr is recorded.
      if (w_fail && !err_sticky) begin
        err_sticky     <= 1'b1;
        first_fail_cyc <= cyc_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ab_lag_checker.sv
// Self-checking bench for ab_lag_checker: directed scenarios plus randomized
// traffic compared each cycle against a queue-based reference model.
module tb_ab_lag_checker;

  localparam int LAG   = 2;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             clr = 1'b0;
  logic             a   = 1'b0;
  logic             b   = 1'b0;
  logic             pass_p;
  logic             fwd_fail_p;
  logic             bwd_fail_p;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err_sticky;
  logic [CNT_W-1:0] first_fail_cyc;
  logic [CNT_W-1:0] cyc_cnt;
  logic [1:0]       state;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: a queue of the a samples taken while warming/armed.
  bit mActive;
  bit aq[$];
  int mPass, mFailCnt, mCyc, mFfc;
  bit mSticky, mPp, mFp, mBp;

  ab_lag_checker #(.LAG(LAG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .pass_p(pass_p), .fwd_fail_p(fwd_fail_p), .bwd_fail_p(bwd_fail_p),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
    .first_fail_cyc(first_fail_cyc), .cyc_cnt(cyc_cnt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int satInc(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  function automatic int modelState();
    if (!mActive) return 0;
    return (aq.size() < LAG) ? 1 : 2;
  endfunction

  task automatic modelStep(input bit iRst, input bit iEn, input bit iClr, input bit iA, input bit iB);
    bit chkNow;
    bit x;
    if (iRst || iClr) begin
      mPass = 0; mFailCnt = 0; mCyc = 0; mFfc = 0;
      mSticky = 0; mPp = 0; mFp = 0; mBp = 0;
      aq.delete();
      mActive = iRst ? 1'b0 : iEn;
    end else if (!iEn) begin
      mActive = 0;
      aq.delete();
      mPp = 0; mFp = 0; mBp = 0;
    end else begin
      chkNow = mActive && (aq.size() == LAG);
      x      = chkNow ? aq[0] : 1'b0;
      mPp = chkNow &&  x &&  iB;
      mFp = chkNow &&  x && !iB;
      mBp = chkNow && !x &&  iB;
      if (mPp) mPass = satInc(mPass);
      if (mFp || mBp) begin
        if (!mSticky) begin
          mSticky = 1;
          mFfc    = mCyc;
        end
        mFailCnt = satInc(mFailCnt);
      end
      mCyc = satInc(mCyc);
      if (mActive) begin
        aq.push_back(iA);
        if (aq.size() > LAG) void'(aq.pop_front());
      end
      mActive = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    chk("pass_p",         32'(pass_p),         32'(mPp));
    chk("fwd_fail_p",     32'(fwd_fail_p),     32'(mFp));
    chk("bwd_fail_p",     32'(bwd_fail_p),     32'(mBp));
    chk("pass_cnt",       32'(pass_cnt),       32'(mPass));
    chk("fail_cnt",       32'(fail_cnt),       32'(mFailCnt));
    chk("err_sticky",     32'(err_sticky),     32'(mSticky));
    chk("first_fail_cyc", 32'(first_fail_cyc), 32'(mFfc));
    chk("cyc_cnt",        32'(cyc_cnt),        32'(mCyc));
    chk("state",          32'(state),          32'(modelState()));
  endtask

  task automatic applyStimulus(input bit iRst, input bit iEn, input bit iClr, input bit iA, input bit iB);
    @(negedge clk);
    rst = iRst; en = iEn; clr = iClr; a = iA; b = iB;
    @(posedge clk);
    modelStep(iRst, iEn, iClr, iA, iB);
    #1;
    checkOutput();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    applyStimulus(1, 1, 0, 1, 1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);

    // a@5, b@7 -> pass pulse after cycle 7
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(0, 1, 0, c == 5, c == 7);
      if (c == 6) chk("pass_early", 32'(pass_p), 32'd0);
      if (c == 7) begin
        chk("pass_at8", 32'(pass_p), 32'd1);
        chk("pass_cnt1", 32'(pass_cnt), 32'd1);
        chk("fail_cnt0", 32'(fail_cnt), 32'd0);
      end
    end

    // a@5, b missing at 7 -> forward fail, first_fail_cyc=7
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(0, 1, 0, c == 5, 1'b0);
      if (c == 7) begin
        chk("fwd_at8", 32'(fwd_fail_p), 32'd1);
        chk("fwd_sticky", 32'(err_sticky), 32'd1);
        chk("fwd_ffc", 32'(first_fail_cyc), 32'd7);
      end
    end

    // b in warmup ignored; b@4 without a@2 -> backward fail
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(0, 1, 0, 1'b0, (c == 1) || (c == 4));
      if (c == 1) begin
        chk("warm_no_pulse", 32'({pass_p, fwd_fail_p, bwd_fail_p}), 32'd0);
        chk("warm_state", 32'(state), 32'd1);
      end
      if (c == 4) chk("bwd_at5", 32'(bwd_fail_p), 32'd1);
    end

    // pass_cnt saturation
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 23; c++) applyStimulus(0, 1, 0, 1'b1, 1'b1);
    chk("pass_sat", 32'(pass_cnt), 32'd15);

    // clr between a and b discards the event
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(0, 1, c == 6, c == 5, c == 7);
      if (c == 6) begin
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_cyc", 32'(cyc_cnt), 32'd0);
      end
      if (c == 7) chk("clr_no_pulse", 32'({pass_p, fwd_fail_p, bwd_fail_p}), 32'd0);
    end

    // en drop after a@5 discards its sample, warmup restarts
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(0, c != 6, 0, c == 5, 1'b0);
      if (c == 6) chk("en0_idle", 32'(state), 32'd0);
      if (c == 8) chk("en_warm2", 32'(state), 32'd1);
      if (c == 9) chk("en_armed", 32'(state), 32'd2);
    end
    chk("en0_no_fail", 32'(fail_cnt), 32'd0);

    // rst mid-operation discards pending event
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(c == 6, 1'b1, 0, c == 5, c == 7);
      if (c == 7) chk("rst_no_pulse", 32'({pass_p, fwd_fail_p, bwd_fail_p}), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(63) == 0, $urandom_range(7) != 0,
                    $urandom_range(24) == 0, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ab_lag_checker.md
AB_LAG_CHECKER -- requirements
Module: ab_lag_checker

Interface
REQ-001 The block SHALL take parameter LAG, default 2, meaning the cycle distance between a and b being checked; legal range 1..8.
REQ-002 The block SHALL take parameter CNT_W, default 16, meaning the width of all counters and the captured cycle index.
REQ-003 The block SHALL run from one clock with a synchronous, active-high reset: clk, rst.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port en, input, 1 bit: checking enable.
REQ-007 Port clr, input, 1 bit: synchronous clear of history, counters and sticky state.
REQ-008 Port a, input, 1 bit: antecedent signal, sampled on clk.
REQ-009 Port b, input, 1 bit: consequent signal, sampled on clk.
REQ-010 Port pass_p, output, 1 bit: registered one-cycle pass pulse.
REQ-011 Port fwd_fail_p, output, 1 bit: registered pulse for a without b LAG cycles later.
REQ-012 Port bwd_fail_p, output, 1 bit: registered pulse for b without a LAG cycles earlier.
REQ-013 Port pass_cnt, output, CNT_W bits: saturating pass count.
REQ-014 Port fail_cnt, output, CNT_W bits: saturating fail count.
REQ-015 Port err_sticky, output, 1 bit: set on the first fail.
REQ-016 Port first_fail_cyc, output, CNT_W bits: cyc_cnt value at the first fail.
REQ-017 Port cyc_cnt, output, CNT_W bits: enabled-cycle index.
REQ-018 Port state, output, 2 bits: IDLE=0, WARMUP=1, ARMED=2.

Function
REQ-019 The block SHALL hold history register h[LAG-1:0] of past a samples; h[LAG-1] SHALL equal a sampled LAG enabled cycles earlier.
REQ-020 The block SHALL implement a state machine with these transitions:
- IDLE->WARMUP when en=1.
- WARMUP->ARMED after LAG enabled cycles.
- Any state->IDLE when en=0.
REQ-021 On entry to IDLE, h and the warmup count SHALL be zeroed; counters SHALL hold their values.
REQ-022 In ARMED with en=1, at cycle t, let x=h[LAG-1] and y=b(t):
- x=1, y=1: pass.
- x=1, y=0: forward fail.
- x=0, y=1: backward fail.
- x=0, y=0: vacuous, no event.
REQ-023 Event pulses SHALL assert at t+1 for exactly one cycle; fwd_fail_p and bwd_fail_p SHALL be mutually exclusive.
REQ-024 No event SHALL be produced in IDLE or WARMUP, even if a or b toggles.
REQ-025 pass_cnt SHALL increment by 1 per pass and fail_cnt by 1 per fail, each saturating at 2^CNT_W-1 with no wrap.
REQ-026 cyc_cnt SHALL increment each en=1 cycle in WARMUP or ARMED, saturating; the first enabled cycle after rst/clr SHALL have index 0.
REQ-027 On the first fail since rst/clr, first_fail_cyc SHALL capture cyc_cnt of cycle t and err_sticky SHALL set, both visible at t+1; later fails SHALL not alter them.
REQ-028 clr=1 SHALL zero h, counters, err_sticky, first_fail_cyc, cyc_cnt and pulses next cycle, then enter WARMUP if en=1, else IDLE.
REQ-029 An event due in a clr cycle SHALL be discarded.
REQ-030 Priority SHALL be rst > clr > en=0 > normal operation.
REQ-031 Overlapping antecedents (a high on consecutive cycles) SHALL each be checked independently.

Reset
REQ-032 With rst=1 at a clk edge, all outputs SHALL read 0 and state SHALL read IDLE next cycle.
REQ-033 rst asserted mid-operation SHALL discard history and any pending event; no pulse SHALL appear after rst.

Verification
REQ-034 LAG=2, en=1: a=1 at cycle 5, b=1 at cycle 7 -> pass_p at 8, pass_cnt=1, fail_cnt=0.
REQ-035 a=1 at cycle 5, b=0 at 7 -> fwd_fail_p at 8, err_sticky=1, first_fail_cyc=7 (en from cycle 0).
REQ-036 b=1 at cycle 1 (WARMUP) -> no pulse; b=1 at cycle 4 with a=0 at cycle 2 -> bwd_fail_p at 5.
REQ-037 CNT_W=4, a=b=1 held for 20 ARMED cycles -> pass_cnt saturates at 15.
REQ-038 a=1 at cycle 5, clr at cycle 6, b=1 at 7 -> no pulse, counters 0, state WARMUP at 7.
REQ-039 en=0 at cycle 6 after a=1 at 5, en=1 again at 7 -> no event from the cycle-5 sample; WARMUP lasts 2 cycles.
